md5_core_dispatcher: RTL and testbench
======================================

// Module: md5_core_dispatcher
// PURPOSE
//  Schedules candidate messages from the bus front end onto NUM_CORES parallel md5 hash cores.
//  Runs in the clk (150 MHz) domain, between the rpi bus command logic and the core array inside top_md5.
//  Hands out candidates round-robin, tags each with its run index, stops on the first match and reports that index.
//  Flags run completion to the bus_done/bus_match logic.
// PARAMETERS
//  NUM_CORES  4    number of md5 cores served (>=1)
//  MSG_W      448  candidate message width in bits
//  IDX_W      32   width of candidate counter / match index
// PORTS
//  clk          in   1          core clock; only clock in the block
//  reset        in   1          synchronous, active-high; clears all state
//  start        in   1          pulse: begin a run (accepted in IDLE or FINISH only)
//  total_count  in   IDX_W      candidates in the run; sampled on accepted start
//  cand_valid   in   1          upstream candidate valid
//  cand_data    in   MSG_W      candidate message
//  cand_ready   out  1          dispatcher accepts cand_data this cycle
//  core_start   out  NUM_CORES  one-hot, 1-cycle load pulse to a core
//  core_data    out  MSG_W      message bus shared by all cores; valid with core_start
//  core_busy    in   NUM_CORES  core still hashing
//  core_done    in   NUM_CORES  1-cycle pulse: core result valid
//  core_match   in   NUM_CORES  qualified by core_done[i]: digest equals target
//  busy         out  1          run in progress (RUN or DRAIN)
//  done         out  1          level: run finished; held until next accepted start
//  match        out  1          level: run ended on a match; valid while done=1
//  match_index  out  IDX_W      0-based index of the matching candidate; valid while match=1
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, issued=0, outstanding=0. All outputs 0 (core_data 0).
//  FSM:
//   IDLE/FINISH --start--> RUN. Clears issued, outstanding, ptr, done, match, match_index. Latches total_count.
//   RUN --issued==total--> DRAIN. With total_count==0, the FSM goes straight to FINISH on the next cycle, match=0.
//   DRAIN --outstanding==0--> FINISH, match=0.
//   RUN/DRAIN --any core_done&core_match on an outstanding core--> FINISH, match=1.
//  cand_ready is high only when all hold: state==RUN, issued<total, outstanding[ptr]==0, core_busy[ptr]==0.
//  Dispatch fires on cand_valid&&cand_ready in cycle k:
//   - core_start[ptr]=1 and core_data=cand_data in cycle k+1 (registered; core_data holds until next dispatch).
//   - tag[ptr]<=issued; issued++; outstanding[ptr]<=1.
//   - ptr<=(ptr+1) mod NUM_CORES. Strict in-order round-robin; a busy target stalls, no skipping.
//  core_done[i] clears outstanding[i]. core_done on a non-outstanding core is ignored, including its core_match.
//  Match in cycle m: done=1, match=1, match_index=tag[i] in cycle m+1. busy=0 in m+1. No further core_start.
//  Simultaneous matches: lowest core number wins.
//  Results arriving after FINISH are ignored. In-flight cores are abandoned; outstanding is cleared on the next start.
//  Same-cycle dispatch to core j and done from core j cannot occur, because ready requires outstanding[j]==0.
//   Done from core i!=ptr in the same cycle as a dispatch: both take effect.
//  Dispatch and match in the same cycle: the match wins. The dispatch is still taken (issued++), but no core_start is issued.
//  start while in RUN/DRAIN is ignored. reset mid-run aborts immediately to IDLE with all outputs 0.
//  issued and tag widths are IDX_W with no wrap; total_count max = 2^IDX_W-1.
//  done/match/match_index are registered; busy = (state==RUN||state==DRAIN), registered.
// TESTING
//  1. reset 3 cycles -> all outputs 0; start with total_count=0 -> done=1, match=0 two cycles after start; busy never high.
//  2. NUM_CORES=4, total=8, no matches, core done 5 cycles after start:
//     core_start order 1,2,4,8,1,2,4,8; done=1 only after 8th core_done; match=0.
//  3. total=10, core_match with candidate index 6 (core 2) -> done=1, match=1, match_index=6 next cycle;
//     no core_start afterwards; later core_done pulses are ignored.
//  4. Cores 1 and 3 done+match in the same cycle (tags 5 and 7) -> match_index=5; core 0 held busy stalls cand_ready until it clears.
//  5. Assert reset mid-RUN with 3 cores outstanding -> IDLE, outputs 0.
//     A new start with total=2 dispatches to cores 0,1 and completes normally; start pulsed during RUN has no effect.

Source files
------------

// File: rtl/md5_core_dispatcher.sv
// Round-robin dispatcher feeding candidate messages to NUM_CORES md5 cores.
// Tags each dispatch with its run index and stops the run on the first reported match.
module md5_core_dispatcher #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned MSG_W     = 448,
    parameter int unsigned IDX_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [IDX_W-1:0]     total_count,
    input  logic                 cand_valid,
    input  logic [MSG_W-1:0]     cand_data,
    output logic                 cand_ready,
    output logic [NUM_CORES-1:0] core_start,
    output logic [MSG_W-1:0]     core_data,
    input  logic [NUM_CORES-1:0] core_busy,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic [NUM_CORES-1:0] core_match,
    output logic                 busy,
    output logic                 done,
    output logic                 match,
    output logic [IDX_W-1:0]     match_index
);
    localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [PTR_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_issued;
    logic [IDX_W-1:0]     r_total;
    logic [NUM_CORES-1:0] r_outstanding;
    logic [IDX_W-1:0]     r_tag [NUM_CORES];
    logic [NUM_CORES-1:0] r_core_start;
    logic [MSG_W-1:0]     r_core_data;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_match;
    logic [IDX_W-1:0]     r_match_index;

    logic                 w_active;
    logic                 w_ready;
    logic                 w_fire;
    logic                 w_accept_start;
    logic [NUM_CORES-1:0] w_hit;
    logic                 w_hit_any;
    logic                 w_found;
    logic [PTR_W-1:0]     w_hit_idx;
    logic [PTR_W-1:0]     w_ptr_next;
    logic [NUM_CORES-1:0] w_ptr_onehot;

    assign w_active       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_hit          = core_done & core_match & r_outstanding & {NUM_CORES{w_active}};
    assign w_hit_any      = |w_hit;
    assign w_ready        = (r_state == S_RUN) && (r_issued < r_total)
                            && !r_outstanding[r_ptr] && !core_busy[r_ptr];
    assign w_fire         = cand_valid && w_ready;
    assign w_accept_start = start && ((r_state == S_IDLE) || (r_state == S_FINISH));
    assign w_ptr_next     = (r_ptr == PTR_W'(NUM_CORES - 1)) ? '0 : r_ptr + PTR_W'(1);
    assign w_ptr_onehot   = NUM_CORES'(1) << r_ptr;

    // Simultaneous matches resolve to the lowest core number.
    always_comb begin
        w_hit_idx = '0;
        w_found   = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (w_hit[i] && !w_found) begin
                w_hit_idx = PTR_W'(i);
                w_found   = 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_FINISH: if (start) w_next = S_RUN;
            S_RUN: begin
                if (w_hit_any)
                    w_next = S_FINISH;
                else if (r_issued == r_total)
                    w_next = (r_total == '0) ? S_FINISH : S_DRAIN;
            end
            S_DRAIN: if (w_hit_any || (r_outstanding == '0)) w_next = S_FINISH;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr         <= '0;
            r_issued      <= '0;
            r_total       <= '0;
            r_outstanding <= '0;
            r_core_start  <= '0;
            r_core_data   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_match       <= 1'b0;
            r_match_index <= '0;
            for (int unsigned i = 0; i < NUM_CORES; i++) r_tag[i] <= '0;
        end else begin
            r_core_start <= '0;
            r_busy       <= (w_next == S_RUN) || (w_next == S_DRAIN);
            if (w_accept_start) begin
                r_issued      <= '0;
                r_outstanding <= '0;
                r_ptr         <= '0;
                r_done        <= 1'b0;
                r_match       <= 1'b0;
                r_match_index <= '0;
                r_total       <= total_count;
                // An empty run passes through RUN for one cycle without ever reporting busy.
                r_busy        <= (total_count != '0);
            end else begin
                r_outstanding <= (r_outstanding & ~core_done) | (w_fire ? w_ptr_onehot : '0);
                if (w_fire) begin
                    r_tag[r_ptr] <= r_issued;
                    r_issued     <= r_issued + IDX_W'(1);
                    r_ptr        <= w_ptr_next;
                    r_core_data  <= cand_data;
                    if (!w_hit_any) r_core_start <= w_ptr_onehot;
                end
                if (w_active && (w_next == S_FINISH)) begin
                    r_done  <= 1'b1;
                    r_match <= w_hit_any;
                    if (w_hit_any) r_match_index <= r_tag[w_hit_idx];
                end
            end
        end
    end

    assign cand_ready  = w_ready;
    assign core_start  = r_core_start;
    assign core_data   = r_core_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign match       = r_match;
    assign match_index = r_match_index;
endmodule

// File: tb/tb_md5_core_dispatcher.sv
// Directed bench for md5_core_dispatcher with a simple latency model standing in for the cores.
module tb_md5_core_dispatcher;
    localparam int NC  = 4;
    localparam int MW  = 448;
    localparam int IW  = 32;
    localparam int LAT = 5;

    logic          clk;
    logic          reset;
    logic          start;
    logic [IW-1:0] total_count;
    logic          cand_valid;
    logic [MW-1:0] cand_data;
    logic          cand_ready;
    logic [NC-1:0] core_start;
    logic [MW-1:0] core_data;
    logic [NC-1:0] core_busy;
    logic [NC-1:0] core_done;
    logic [NC-1:0] core_match;
    logic          busy;
    logic          done;
    logic          match;
    logic [IW-1:0] match_index;

    int checks;
    int failures;

    bit            manual;
    bit            hold0;
    bit            match_driven;
    int            match_cand;
    int            n_acc;
    int            n_starts;
    int            done_pulses;
    int            cnt [NC];
    int            loaded [NC];
    logic [NC-1:0] start_log [$];
    logic [MW-1:0] data_log [$];

    md5_core_dispatcher #(.NUM_CORES(NC), .MSG_W(MW), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset), .start(start), .total_count(total_count),
        .cand_valid(cand_valid), .cand_data(cand_data), .cand_ready(cand_ready),
        .core_start(core_start), .core_data(core_data), .core_busy(core_busy),
        .core_done(core_done), .core_match(core_match), .busy(busy), .done(done),
        .match(match), .match_index(match_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [MW-1:0] pat(int n);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(n);
        return {14{w}};
    endfunction

    // One clock: count acceptances, log core loads, advance the core latency model.
    task automatic step();
        bit acc;
        @(negedge clk);
        acc = cand_valid && cand_ready;
        @(posedge clk);
        #1;
        if (acc) n_acc++;
        cand_data  = pat(n_acc);
        core_done  = '0;
        core_match = '0;
        if (core_start != '0) begin
            start_log.push_back(core_start);
            data_log.push_back(core_data);
        end
        for (int i = 0; i < NC; i++) begin
            if (!manual && cnt[i] != 0) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    core_done[i]  = 1'b1;
                    core_match[i] = (loaded[i] == match_cand);
                    core_busy[i]  = 1'b0;
                    done_pulses++;
                end
            end
            if (core_start[i]) begin
                loaded[i] = n_starts;
                if (!manual) begin
                    cnt[i]       = LAT;
                    core_busy[i] = 1'b1;
                end
            end
        end
        if (core_start != '0) n_starts++;
        if (hold0) core_busy[0] = 1'b1;
        if (core_match != '0) match_driven = 1'b1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NC; i++) begin
            cnt[i]    = 0;
            loaded[i] = -1;
        end
        core_busy    = '0;
        core_done    = '0;
        core_match   = '0;
        start_log.delete();
        data_log.delete();
        n_acc        = 0;
        n_starts     = 0;
        done_pulses  = 0;
        match_cand   = -1;
        match_driven = 1'b0;
        hold0        = 1'b0;
        cand_data    = pat(0);
    endtask

    task automatic do_start(int total);
        start       = 1'b1;
        total_count = IW'(total);
        step();
        start       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (match !== 1'b0) begin failures++; $display("FAIL reset_match: got %0b expected 0", match); end
        checks++; if (match_index !== '0) begin failures++; $display("FAIL reset_index: got %0h expected 0", match_index); end
        checks++; if (core_start !== '0) begin failures++; $display("FAIL reset_core_start: got %0h expected 0", core_start); end
        checks++; if (core_data !== '0) begin failures++; $display("FAIL reset_core_data: got %0h expected 0", core_data); end
        checks++; if (cand_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %0b expected 0", cand_ready); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_zero_total();
        bit saw_busy;
        clear_model();
        saw_busy = 1'b0;
        do_start(0);
        if (busy !== 1'b0) saw_busy = 1'b1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_early: got %0b expected 0", done); end
        step();
        if (busy !== 1'b0) saw_busy = 1'b1;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done: got %0b expected 1", done); end
        checks++; if (match !== 1'b0) begin failures++; $display("FAIL zero_match: got %0b expected 0", match); end
        step();
        if (busy !== 1'b0) saw_busy = 1'b1;
        checks++; if (saw_busy !== 1'b0) begin failures++; $display("FAIL zero_busy: got %0b expected 0", saw_busy); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done_hold: got %0b expected 1", done); end
    endtask

    task automatic test_no_match();
        bit early;
        bit saw_busy;
        clear_model();
        manual     = 1'b0;
        early      = 1'b0;
        saw_busy   = 1'b0;
        cand_valid = 1'b1;
        do_start(8);
        for (int c = 0; c < 300 && done !== 1'b1; c++) begin
            step();
            if (busy === 1'b1) saw_busy = 1'b1;
            if (done === 1'b1 && done_pulses < 8) early = 1'b1;
        end
        cand_valid = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL nomatch_done_timeout: got %0b expected 1", done); end
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL nomatch_done_early: got %0b expected 0", early); end
        checks++; if (match !== 1'b0) begin failures++; $display("FAIL nomatch_match: got %0b expected 0", match); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nomatch_busy_end: got %0b expected 0", busy); end
        checks++; if (saw_busy !== 1'b1) begin failures++; $display("FAIL nomatch_busy_run: got %0b expected 1", saw_busy); end
        checks++; if (start_log.size() !== 8) begin failures++; $display("FAIL nomatch_start_count: got %0d expected 8", start_log.size()); end
        for (int k = 0; k < start_log.size() && k < 8; k++) begin
            logic [NC-1:0] e;
            e = NC'(1) << (k % NC);
            checks++; if (start_log[k] !== e) begin failures++; $display("FAIL nomatch_order[%0d]: got %0h expected %0h", k, start_log[k], e); end
            checks++; if (data_log[k] !== pat(k)) begin failures++; $display("FAIL nomatch_data[%0d]: got %0h expected %0h", k, data_log[k], pat(k)); end
        end
    endtask

    task automatic test_match();
        int ns;
        clear_model();
        manual     = 1'b0;
        match_cand = 6;
        cand_valid = 1'b1;
        do_start(10);
        for (int c = 0; c < 300 && !match_driven; c++) step();
        checks++; if (match_driven !== 1'b1) begin failures++; $display("FAIL match_timeout: got %0b expected 1", match_driven); end
        ns = n_starts;
        step();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL match_done: got %0b expected 1", done); end
        checks++; if (match !== 1'b1) begin failures++; $display("FAIL match_flag: got %0b expected 1", match); end
        checks++; if (match_index !== 32'd6) begin failures++; $display("FAIL match_index: got %0d expected 6", match_index); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL match_busy: got %0b expected 0", busy); end
        repeat (12) step();
        core_done  = '1;
        core_match = '1;
        repeat (4) step();
        cand_valid = 1'b0;
        checks++; if (n_starts !== ns) begin failures++; $display("FAIL match_no_more_starts: got %0d expected %0d", n_starts, ns); end
        checks++; if (match_index !== 32'd6) begin failures++; $display("FAIL match_index_hold: got %0d expected 6", match_index); end
        checks++; if (done !== 1'b1 || match !== 1'b1) begin failures++; $display("FAIL match_hold: got done=%0b match=%0b expected 1 1", done, match); end
        for (int k = 0; k < start_log.size(); k++) begin
            logic [NC-1:0] e;
            e = NC'(1) << (k % NC);
            checks++; if (start_log[k] !== e) begin failures++; $display("FAIL match_order[%0d]: got %0h expected %0h", k, start_log[k], e); end
        end
    endtask

    task automatic test_simul_match();
        bit stalled;
        clear_model();
        manual     = 1'b1;
        cand_valid = 1'b1;
        do_start(12);
        for (int c = 0; c < 30 && n_starts < 4; c++) step();
        hold0        = 1'b1;
        core_busy[0] = 1'b1;
        step();
        core_done = '1;
        step();
        stalled = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (cand_ready !== 1'b0) stalled = 1'b0;
            step();
        end
        checks++; if (stalled !== 1'b1) begin failures++; $display("FAIL simul_ready_stall: got %0b expected 1", stalled); end
        checks++; if (n_starts !== 4) begin failures++; $display("FAIL simul_stall_starts: got %0d expected 4", n_starts); end
        hold0        = 1'b0;
        core_busy[0] = 1'b0;
        for (int c = 0; c < 30 && n_starts < 8; c++) step();
        step();
        core_done  = 4'b1010;
        core_match = 4'b1010;
        step();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL simul_done: got %0b expected 1", done); end
        checks++; if (match !== 1'b1) begin failures++; $display("FAIL simul_match: got %0b expected 1", match); end
        checks++; if (match_index !== 32'd5) begin failures++; $display("FAIL simul_index: got %0d expected 5", match_index); end
        checks++; if (start_log.size() !== 8) begin failures++; $display("FAIL simul_start_count: got %0d expected 8", start_log.size()); end
        for (int k = 0; k < start_log.size() && k < 8; k++) begin
            logic [NC-1:0] e;
            e = NC'(1) << (k % NC);
            checks++; if (start_log[k] !== e) begin failures++; $display("FAIL simul_order[%0d]: got %0h expected %0h", k, start_log[k], e); end
        end
        cand_valid = 1'b0;
    endtask

    task automatic test_reset_midrun();
        clear_model();
        manual     = 1'b1;
        cand_valid = 1'b1;
        do_start(8);
        for (int c = 0; c < 30 && n_starts < 3; c++) step();
        reset = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || match !== 1'b0) begin failures++; $display("FAIL midreset_flags: got busy=%0b done=%0b match=%0b expected 0 0 0", busy, done, match); end
        checks++; if (core_start !== '0) begin failures++; $display("FAIL midreset_core_start: got %0h expected 0", core_start); end
        checks++; if (core_data !== '0) begin failures++; $display("FAIL midreset_core_data: got %0h expected 0", core_data); end
        checks++; if (cand_ready !== 1'b0) begin failures++; $display("FAIL midreset_ready: got %0b expected 0", cand_ready); end
        reset = 1'b0;
        step();
        clear_model();
        manual = 1'b1;
        do_start(2);
        step();
        start       = 1'b1;
        total_count = 32'd5;
        step();
        start = 1'b0;
        for (int c = 0; c < 20 && n_starts < 2; c++) step();
        repeat (4) step();
        checks++; if (n_starts !== 2) begin failures++; $display("FAIL rerun_start_count: got %0d expected 2", n_starts); end
        if (start_log.size() >= 2) begin
            checks++; if (start_log[0] !== 4'b0001 || start_log[1] !== 4'b0010) begin failures++; $display("FAIL rerun_order: got %0h %0h expected 1 2", start_log[0], start_log[1]); end
            checks++; if (data_log[1] !== pat(1)) begin failures++; $display("FAIL rerun_data: got %0h expected %0h", data_log[1], pat(1)); end
        end
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL rerun_drain: got busy=%0b done=%0b expected 1 0", busy, done); end
        core_done = 4'b0011;
        for (int c = 0; c < 6 && done !== 1'b1; c++) step();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL rerun_done: got %0b expected 1", done); end
        checks++; if (match !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rerun_end: got match=%0b busy=%0b expected 0 0", match, busy); end
        cand_valid = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        manual      = 1'b0;
        reset       = 1'b1;
        start       = 1'b0;
        total_count = '0;
        cand_valid  = 1'b0;
        clear_model();
        test_reset();
        test_zero_total();
        test_no_match();
        test_match();
        test_simul_match();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
